// File: rtl/ace_pcgen.sv
// +--------------------------------------------------------------------------+
// | Module  : ace_pcgen                                                      |
// | Purpose : fetch-PC sequencer for the two-stage (f0/f1) fetch pipeline;   |
// |           selects flush / f1 override / f0 prediction / hold each cycle. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ace_pcgen #(
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int          FLUSH_BUBBLES = 1,
    parameter int          CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_rt_i,
    input  logic [63:0]      flush_pc_rt_i,
    input  logic             override_vld_f1_i,
    input  logic [63:0]      override_pc_f1_i,
    input  logic [63:0]      nxt_pc_f0_i,
    input  logic             icache_stall_i,
    input  logic             instbuf_full_i,
    input  logic             bob_stall_i,
    output logic [63:0]      pc_f0_o,
    output logic             pc_f0_vld_o,
    output logic [63:0]      pc_f1_o,
    output logic             pc_f1_vld_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        BOOT    = 2'b00,
        RUN     = 2'b01,
        HOLD    = 2'b10,
        RECOVER = 2'b11
    } state_t;

    localparam logic [63:0]      PC_MASK  = ~64'h3;
    localparam logic [3:0]       BUBBLES  = 4'(FLUSH_BUBBLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [63:0]      BOOT_PC  = RESET_PC & PC_MASK;

    state_t           state, state_nxt;
    logic [63:0]      pc_f0, pc_f0_nxt;
    logic [63:0]      pc_f1, pc_f1_nxt;
    logic             f0_vld, f0_vld_nxt;
    logic             f1_vld, f1_vld_nxt;
    logic [3:0]       bubble, bubble_nxt;
    logic [CNT_W-1:0] redirect_cnt, flush_cnt;
    logic             redirect_inc, flush_inc;
    logic             hold;

    assign hold = icache_stall_i | instbuf_full_i | bob_stall_i;

    always_comb begin
        state_nxt    = state;
        pc_f0_nxt    = pc_f0;
        pc_f1_nxt    = pc_f1;
        f0_vld_nxt   = f0_vld;
        f1_vld_nxt   = f1_vld;
        bubble_nxt   = bubble;
        redirect_inc = 1'b0;
        flush_inc    = 1'b0;

        if (flush_rt_i) begin
            // Flush beats everything, including a same-cycle override.
            pc_f0_nxt  = flush_pc_rt_i & PC_MASK;
            f1_vld_nxt = 1'b0;
            flush_inc  = 1'b1;
            bubble_nxt = BUBBLES;
            if (BUBBLES == 4'd0) begin
                state_nxt  = RUN;
                f0_vld_nxt = 1'b1;
            end else begin
                state_nxt  = RECOVER;
                f0_vld_nxt = 1'b0;
            end
        end else begin
            case (state)
                BOOT: begin
                    state_nxt  = RUN;
                    pc_f0_nxt  = BOOT_PC;
                    f0_vld_nxt = 1'b1;
                end
                RUN, HOLD: begin
                    if (hold) begin
                        state_nxt = HOLD;
                    end else if (override_vld_f1_i) begin
                        state_nxt    = RUN;
                        pc_f0_nxt    = override_pc_f1_i & PC_MASK;
                        pc_f1_nxt    = pc_f0;
                        f1_vld_nxt   = 1'b0;
                        redirect_inc = 1'b1;
                    end else begin
                        state_nxt  = RUN;
                        pc_f0_nxt  = nxt_pc_f0_i & PC_MASK;
                        pc_f1_nxt  = pc_f0;
                        f1_vld_nxt = f0_vld;
                    end
                end
                RECOVER: begin
                    // Bubbles drain regardless of hold; hold only picks the exit state.
                    bubble_nxt = bubble - 4'd1;
                    if (bubble == 4'd1) begin
                        state_nxt  = hold ? HOLD : RUN;
                        f0_vld_nxt = 1'b1;
                    end
                end
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= BOOT;
            pc_f0        <= BOOT_PC;
            pc_f1        <= BOOT_PC;
            f0_vld       <= 1'b0;
            f1_vld       <= 1'b0;
            bubble       <= 4'd0;
            redirect_cnt <= '0;
            flush_cnt    <= '0;
        end else begin
            state  <= state_nxt;
            pc_f0  <= pc_f0_nxt;
            pc_f1  <= pc_f1_nxt;
            f0_vld <= f0_vld_nxt;
            f1_vld <= f1_vld_nxt;
            bubble <= bubble_nxt;
            if (redirect_inc && redirect_cnt != CNT_MAX) begin
                redirect_cnt <= redirect_cnt + CNT_ONE;
            end
            if (flush_inc && flush_cnt != CNT_MAX) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

    assign pc_f0_o        = pc_f0;
    assign pc_f0_vld_o    = f0_vld;
    assign pc_f1_o        = pc_f1;
    assign pc_f1_vld_o    = f1_vld;
    assign state_o        = state;
    assign redirect_cnt_o = redirect_cnt;
    assign flush_cnt_o    = flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ace_pcgen.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_ace_pcgen                                                   |
// | Purpose : directed plus randomized self-checking bench for ace_pcgen.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ace_pcgen;

    localparam logic [63:0] RST_PC = 64'h1000;
    localparam int          BUB    = 2;
    localparam int          CW     = 2;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          flush_rt_i = 1'b0;
    logic [63:0]   flush_pc_rt_i = '0;
    logic          override_vld_f1_i = 1'b0;
    logic [63:0]   override_pc_f1_i = '0;
    logic [63:0]   nxt_pc_f0_i = '0;
    logic          icache_stall_i = 1'b0;
    logic          instbuf_full_i = 1'b0;
    logic          bob_stall_i = 1'b0;
    logic [63:0]   pc_f0_o, pc_f1_o;
    logic          pc_f0_vld_o, pc_f1_vld_o;
    logic [1:0]    state_o;
    logic [CW-1:0] redirect_cnt_o, flush_cnt_o;

    ace_pcgen #(.RESET_PC(RST_PC), .FLUSH_BUBBLES(BUB), .CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .flush_rt_i(flush_rt_i), .flush_pc_rt_i(flush_pc_rt_i),
        .override_vld_f1_i(override_vld_f1_i), .override_pc_f1_i(override_pc_f1_i),
        .nxt_pc_f0_i(nxt_pc_f0_i), .icache_stall_i(icache_stall_i),
        .instbuf_full_i(instbuf_full_i), .bob_stall_i(bob_stall_i),
        .pc_f0_o(pc_f0_o), .pc_f0_vld_o(pc_f0_vld_o),
        .pc_f1_o(pc_f1_o), .pc_f1_vld_o(pc_f1_vld_o),
        .state_o(state_o), .redirect_cnt_o(redirect_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: state codes 0 BOOT, 1 RUN, 2 HOLD, 3 RECOVER.
    logic [63:0] m_f0, m_f1;
    bit          m_f0v, m_f1v;
    int          m_state, m_bub, m_rc, m_fc;

    function automatic logic [63:0] align(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

    task automatic model_reset();
        m_f0 = RST_PC; m_f1 = RST_PC; m_f0v = 0; m_f1v = 0;
        m_state = 0; m_bub = 0; m_rc = 0; m_fc = 0;
    endtask

    task automatic model_step();
        bit hold;
        hold = icache_stall_i | instbuf_full_i | bob_stall_i;
        if (flush_rt_i) begin
            m_f0 = align(flush_pc_rt_i);
            m_f1v = 0;
            m_fc = (m_fc < CMAX) ? m_fc + 1 : m_fc;
            m_bub = BUB;
            m_state = (BUB == 0) ? 1 : 3;
            m_f0v = (BUB == 0);
        end else if (m_state == 0) begin
            m_state = 1; m_f0 = RST_PC; m_f0v = 1;
        end else if (m_state == 3) begin
            m_bub = m_bub - 1;
            if (m_bub == 0) begin
                m_state = hold ? 2 : 1;
                m_f0v = 1;
            end
        end else if (hold) begin
            m_state = 2;
        end else begin
            m_f1 = m_f0;
            m_f1v = override_vld_f1_i ? 1'b0 : m_f0v;
            m_f0 = align(override_vld_f1_i ? override_pc_f1_i : nxt_pc_f0_i);
            if (override_vld_f1_i && m_rc < CMAX) m_rc = m_rc + 1;
            m_state = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc_f0", pc_f0_o, m_f0);
        chk("pc_f0_vld", 64'(pc_f0_vld_o), 64'(m_f0v));
        chk("pc_f1", pc_f1_o, m_f1);
        chk("pc_f1_vld", 64'(pc_f1_vld_o), 64'(m_f1v));
        chk("state", 64'(state_o), 64'(m_state));
        chk("redirect_cnt", 64'(redirect_cnt_o), 64'(m_rc));
        chk("flush_cnt", 64'(flush_cnt_o), 64'(m_fc));
    endtask

    task automatic step();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic clear_inputs();
        flush_rt_i = 0; override_vld_f1_i = 0;
        icache_stall_i = 0; instbuf_full_i = 0; bob_stall_i = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] saved;
        #2;
        do_reset();

        // Boot: RUN with RESET_PC live, then RESET_PC moves to f1.
        nxt_pc_f0_i = 64'h1020;
        step();
        chk("boot_pc_f0", pc_f0_o, 64'h1000);
        chk("boot_vld", 64'(pc_f0_vld_o), 64'd1);
        step();
        chk("boot_pc_f1", pc_f1_o, 64'h1000);
        chk("boot_next", pc_f0_o, 64'h1020);

        // Streaming, then a 3-cycle icache stall.
        for (int i = 0; i < 4; i++) begin
            nxt_pc_f0_i = m_f0 + 64'd32;
            step();
        end
        saved = pc_f0_o;
        nxt_pc_f0_i = saved + 64'd32;
        icache_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_f0_o, saved);
            chk("stall_state", 64'(state_o), 64'd2);
        end
        icache_stall_i = 0;
        step();
        chk("resume_f1", pc_f1_o, saved);

        // Override to 0x1040.
        override_vld_f1_i = 1; override_pc_f1_i = 64'h1040;
        step();
        chk("ovr_pc", pc_f0_o, 64'h1040);
        chk("ovr_f1v", 64'(pc_f1_vld_o), 64'd0);
        chk("ovr_cnt", 64'(redirect_cnt_o), 64'd1);

        // Override under hold is ignored.
        bob_stall_i = 1; override_pc_f1_i = 64'h7000;
        step();
        chk("ovr_hold_cnt", 64'(redirect_cnt_o), 64'd1);
        clear_inputs();
        step();

        // Flush and override together: flush wins.
        flush_rt_i = 1; flush_pc_rt_i = 64'h2003;
        override_vld_f1_i = 1; override_pc_f1_i = 64'h5000;
        step();
        chk("fl_pc", pc_f0_o, 64'h2000);
        chk("fl_fc", 64'(flush_cnt_o), 64'd1);
        chk("fl_rc", 64'(redirect_cnt_o), 64'd1);
        clear_inputs();
        step();
        chk("fl_bub_vld", 64'(pc_f0_vld_o), 64'd0);
        step();
        chk("fl_exit_vld", 64'(pc_f0_vld_o), 64'd1);
        chk("fl_exit_state", 64'(state_o), 64'd1);

        // Flush inside RECOVER with instbuf full: restart, exit to HOLD.
        flush_rt_i = 1; flush_pc_rt_i = 64'h3000;
        step();
        flush_rt_i = 0;
        step();
        flush_rt_i = 1; flush_pc_rt_i = 64'h4006; instbuf_full_i = 1;
        step();
        flush_rt_i = 0;
        step();
        chk("refl_vld", 64'(pc_f0_vld_o), 64'd0);
        step();
        chk("refl_state", 64'(state_o), 64'd2);
        chk("refl_vld1", 64'(pc_f0_vld_o), 64'd1);
        chk("refl_pc", pc_f0_o, 64'h4004);
        clear_inputs();
        step();

        // Four more overrides (five total): counter saturates at 3.
        for (int i = 0; i < 4; i++) begin
            override_vld_f1_i = 1; override_pc_f1_i = {$urandom, $urandom};
            step();
        end
        chk("sat_rc", 64'(redirect_cnt_o), 64'd3);
        clear_inputs();

        // Mid-run reset, then randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            flush_rt_i        = ($urandom_range(0, 99) < 6);
            flush_pc_rt_i     = {$urandom, $urandom};
            override_vld_f1_i = ($urandom_range(0, 99) < 25);
            override_pc_f1_i  = {$urandom, $urandom};
            nxt_pc_f0_i       = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : m_f0 + 64'd32;
            icache_stall_i    = ($urandom_range(0, 99) < 15);
            instbuf_full_i    = ($urandom_range(0, 99) < 10);
            bob_stall_i       = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 199) == 0) begin
                clear_inputs();
                do_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
